// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch/issue unit and the control decoder:
// opcode constants, fetch FSM state encoding and next-PC select codes.
package instr_fetch_pkg;

    localparam logic [3:0] OP_TYPEA = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_BR_WAIT  = 3'd3,
        ST_HALT     = 3'd4
    } fetch_state_t;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_JMP = 2'd1;
    localparam logic [1:0] NPC_BR  = 2'd2;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BLT) || (op == OP_BGT) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC select: sequential (+2), 13-bit jump within the
// current 8 KiB region, or resolved branch (taken target / fall-through).
module instr_fetch_next_pc
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        sel,
    input  logic [11:0]       jmp_imm,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] npc
);

    logic [ADDR_W-1:0] pc_plus2;
    logic              br_target_unused;

    assign pc_plus2         = pc + ADDR_W'(2);
    // instructions are halfword aligned, so the target's low bit is dropped
    assign br_target_unused = br_target[0];

    always_comb begin
        npc = pc_plus2;
        case (sel)
            NPC_JMP: npc = {pc_plus2[ADDR_W-1:13], jmp_imm, 1'b0};
            NPC_BR:  npc = br_taken ? {br_target[ADDR_W-1:1], 1'b0} : pc_plus2;
            default: npc = pc_plus2;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: owns the PC, fetches over req/ack and hands
// each word to the decoder over valid/ready; all outputs come from registers.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               br_resolve,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               halted
);

    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx, instr_pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [3:0]         op;
    logic [1:0]         npc_sel;
    logic               fetch_done, accept, resolve, pc_load;

    assign op         = instr_q[INSTR_W-1 -: 4];
    assign fetch_done = (state == ST_FETCH) && imem_ack;
    assign accept     = (state == ST_ISSUE) && instr_ready;
    assign resolve    = (state == ST_BR_WAIT) && br_resolve;
    // branches and halt park the PC; everything else moves it on acceptance
    assign pc_load    = resolve || (accept && !is_branch(op) && (op != OP_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RST_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RST_WAIT: state_nx = ST_FETCH;
            ST_FETCH:    if (imem_ack) state_nx = ST_ISSUE;
            ST_ISSUE: begin
                if (instr_ready) begin
                    if (is_branch(op))       state_nx = ST_BR_WAIT;
                    else if (op == OP_HALT)  state_nx = ST_HALT;
                    else                     state_nx = ST_FETCH;
                end
            end
            ST_BR_WAIT:  if (br_resolve) state_nx = ST_FETCH;
            ST_HALT:     state_nx = ST_HALT;
            default:     state_nx = ST_RST_WAIT;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state)
            ST_FETCH: imem_req    = 1'b1;
            ST_ISSUE: instr_valid = 1'b1;
            ST_HALT:  halted      = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        npc_sel = NPC_SEQ;
        if (state == ST_BR_WAIT) npc_sel = NPC_BR;
        else if (op == OP_JMP)   npc_sel = NPC_JMP;
    end

    instr_fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc        (pc),
        .sel       (npc_sel),
        .jmp_imm   (instr_q[11:0]),
        .br_taken  (br_taken),
        .br_target (br_target),
        .npc       (pc_nx)
    );

    // PC is untouched between fetch and resolution, so it still names the
    // branch/jump being retired when pc_nx is computed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            if (fetch_done) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
            end
            if (pc_load) pc <= pc_nx;
        end
    end

    assign imem_addr = pc;
    assign instr     = instr_q;
    assign opcode    = op;
    assign instr_pc  = instr_pc_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue unit for the 4-bit-opcode single-issue CPU. It owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents each word and its opcode to the control decoder over a valid/ready handshake. It sequences the next PC for sequential, jump, branch and halt instructions.

## Interface
- ADDR_W, 16, PC and instruction-memory address width (byte address)
- INSTR_W, 16, instruction word width; opcode is instr[15:12]
- RESET_PC, 16'h0000, PC loaded on reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, equals PC
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  INSTR_W  fetched word
- instr_valid  out  1  instruction available to decoder
- instr_ready  in  1  decoder accepts the instruction
- instr  out  INSTR_W  issued instruction word
- opcode  out  4  instr[15:12]
- instr_pc  out  ADDR_W  address of the issued instruction
- br_resolve  in  1  branch outcome valid (one-cycle pulse)
- br_taken  in  1  branch taken, sampled with br_resolve
- br_target  in  ADDR_W  taken-branch target, sampled with br_resolve
- halted  out  1  halt instruction has been issued

## Operation
- States: RST_WAIT, FETCH, ISSUE, BR_WAIT, HALT. Reset enters RST_WAIT.
- RST_WAIT: one cycle, no outputs active, then FETCH.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack at a clock edge: latch imem_rdata into instr, PC into instr_pc, go ISSUE.
- ISSUE: instr_valid=1; instr/opcode/instr_pc held stable until accepted. On instr_ready:
  - 1100 jmp: PC <= {PC_plus2[15:13], instr[11:0], 1'b0}; FETCH.
  - 0100 blt, 0101 bgt, 0110 beq: BR_WAIT.
  - 1111 halt: HALT.
  - all others (including undefined opcodes): PC <= PC+2; FETCH.
- BR_WAIT: on br_resolve, PC <= br_taken ? {br_target[15:1],1'b0} : PC+2; FETCH. br_resolve in any other state is ignored.
- HALT: halted=1, imem_req=0, instr_valid=0; left only by rst.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFE + 2 = 16'h0000. br_target bit 0 is forced to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, instr_pc=0, halted=0.
- imem_req, instr_valid and halted are decoded from registered state only; no combinational path from any input to any output.
- Zero-wait memory (ack in the first FETCH cycle) with always-ready decoder: one instruction per 2 cycles.
- imem_addr stable while imem_req=1; request never withdrawn before ack.
- instr_valid never drops without instr_ready; payload does not change while valid and not ready.
- br_resolve in the same cycle the branch is accepted in ISSUE is ignored; resolution is accepted from the first BR_WAIT cycle.
- rst mid-fetch or mid-branch: all state discarded immediately; an imem_ack arriving after reset deassertion but before FETCH is ignored.

## Structure
- Shared package: opcode constants (OP_TYPEA=0000, OP_LW=1000, OP_SW=1011, OP_BLT=0100, OP_BGT=0101, OP_BEQ=0110, OP_JMP=1100, OP_HALT=1111), state encodings; the control decoder uses the same opcode constants.
- One sub-module: next_pc (combinational next-PC select: +2, jump, branch target).

## Test plan
- Reset, RESET_PC=0, memory returns 0000 words with immediate ack, ready=1 -> instr_pc sequence 0,2,4,6 issued on every second cycle.
- Word 16'hC005 at 0x0010 (jmp) -> next imem_addr=0x000A.
- beq at 0x0020, br_resolve with taken=1, target=0x0041 -> next fetch 0x0040; repeat with taken=0 -> next fetch 0x0022.
- instr_ready held low 5 cycles in ISSUE -> instr, opcode, instr_pc unchanged, no new imem_req.
- halt (16'hF000) accepted -> halted=1 next cycle, imem_req stays 0 for 20 cycles; rst -> fetch restarts at RESET_PC.
- PC=0xFFFE, sequential opcode accepted -> next imem_addr=0x0000; rst asserted mid-FETCH -> imem_req=0 asynchronously.
